// File: rtl/smoldvi_bit_sequencer.sv
// smoldvi bit-clock sequencer: pixel clock ring divider, startup/shutdown
// FSM (HOLD/SETTLE/RUN) and per-pixel serializer load strobe.
//
// Ports:
//   clk_bit, rst_n_bit      bit clock, async active-low reset
//   pll_lock                PLL locked (clk_bit domain)
//   en_req                  requested DVI output enable
//   clr_err                 clears phase_err
//   clk_pix                 divided pixel clock, straight from a ring flop
//   pix_phase               phase counter, 0..DIV-1
//   load_strobe             one-cycle serializer load pulse
//   rst_n_pix_req           pixel-domain reset request (active low)
//   dvi_en                  DVI enable
//   state                   0=HOLD 1=SETTLE 2=RUN
//   phase_err               sticky ring-corruption flag
module smoldvi_bit_sequencer #(
  parameter int DIV           = 5,
  parameter int HIGH          = 3,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOAD_PHASE    = 0
) (
  input  logic       clk_bit,
  input  logic       rst_n_bit,
  input  logic       pll_lock,
  input  logic       en_req,
  input  logic       clr_err,
  output logic       clk_pix,
  output logic [3:0] pix_phase,
  output logic       load_strobe,
  output logic       rst_n_pix_req,
  output logic       dvi_en,
  output logic [1:0] state,
  output logic       phase_err
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } st_t;

  localparam logic [DIV-1:0] SEED =
    {{HIGH{1'b1}}, {(DIV-HIGH){1'b0}}};
  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PH_MAX = 4'(DIV - 1);
  localparam logic [3:0] PH_BND = 4'((HIGH + 1) % DIV);
  localparam logic [3:0] PH_LD  = 4'(LOAD_PHASE);

  logic [DIV-1:0] r_ring;
  logic [3:0]     r_phase;
  st_t            r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_rst_pix;
  logic           r_dvi;
  logic           r_load;
  logic           r_err;

  logic [DIV-1:0] w_exp;
  logic           w_bad;
  logic [3:0]     w_ph_nxt;
  logic           w_bnd_nxt;
  logic           w_ld_nxt;

  // The ring must always equal the seed rotated left by the phase count.
  assign w_exp = (SEED << r_phase)
               | (SEED >> (DIV - 32'(r_phase)));
  assign w_bad = (r_ring != w_exp);

  assign w_ph_nxt  = w_bad ? 4'd0 :
                     (r_phase == PH_MAX) ? 4'd0 :
                     r_phase + 4'd1;
  assign w_bnd_nxt = (w_ph_nxt == PH_BND);
  assign w_ld_nxt  = (w_ph_nxt == PH_LD);

  // Divider free-runs in every state so pixel-side syncs keep clocking.
  always_ff @(posedge clk_bit or negedge rst_n_bit) begin
    if (!rst_n_bit) begin
      r_ring  <= SEED;
      r_phase <= 4'd0;
    end else if (w_bad) begin
      r_ring  <= SEED;
      r_phase <= 4'd0;
    end else begin
      r_ring  <= {r_ring[DIV-2:0], r_ring[DIV-1]};
      r_phase <= w_ph_nxt;
    end
  end

  // Set beats clear when both happen together.
  always_ff @(posedge clk_bit or negedge rst_n_bit) begin
    if (!rst_n_bit) begin
      r_err <= 1'b0;
    end else if (w_bad) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_bit or negedge rst_n_bit) begin
    if (!rst_n_bit) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_rst_pix <= 1'b0;
      r_dvi     <= 1'b0;
      r_load    <= 1'b0;
    end else if (!pll_lock) begin
      // Lock loss drops everything at once, not boundary aligned.
      r_state   <= S_HOLD;
      r_rst_pix <= 1'b0;
      r_dvi     <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          r_state   <= S_SETTLE;
          r_cnt     <= CNT_LD;
          r_rst_pix <= 1'b0;
          r_dvi     <= 1'b0;
          r_load    <= 1'b0;
        end
        S_SETTLE: begin
          r_dvi  <= 1'b0;
          r_load <= 1'b0;
          if (w_bad) begin
            r_cnt     <= CNT_LD;
            r_rst_pix <= 1'b0;
          end else if (r_cnt == '0 && w_bnd_nxt) begin
            r_state   <= S_RUN;
            r_rst_pix <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RUN: begin
          if (w_bad) begin
            r_state   <= S_SETTLE;
            r_cnt     <= CNT_LD;
            r_rst_pix <= 1'b0;
            r_dvi     <= 1'b0;
            r_load    <= 1'b0;
          end else begin
            if (w_bnd_nxt) begin
              r_dvi <= en_req;
            end
            // Strobe uses the enable value that will hold next cycle.
            r_load <= w_ld_nxt &&
                      (w_bnd_nxt ? en_req : r_dvi);
          end
        end
        default: begin
          r_state   <= S_HOLD;
          r_rst_pix <= 1'b0;
          r_dvi     <= 1'b0;
          r_load    <= 1'b0;
        end
      endcase
    end
  end

  assign clk_pix       = r_ring[0];
  assign pix_phase     = r_phase;
  assign load_strobe   = r_load;
  assign rst_n_pix_req = r_rst_pix;
  assign dvi_en        = r_dvi;
  assign state         = r_state;
  assign phase_err     = r_err;

endmodule

// File: tb/tb_smoldvi_bit_sequencer.sv
// Bench for smoldvi_bit_sequencer: random and directed stimulus
// against a cycle-level reference model of the sequencing rules.
module tb_smoldvi_bit_sequencer;

  localparam int DIV    = 5;
  localparam int HIGH   = 3;
  localparam int SETTLE = 16;
  localparam int LDP    = 0;
  localparam int BND    = (HIGH + 1) % DIV;

  logic       clk_bit = 1'b0;
  logic       rst_n_bit = 1'b0;
  logic       pll_lock = 1'b0;
  logic       en_req = 1'b0;
  logic       clr_err = 1'b0;
  logic       clk_pix;
  logic [3:0] pix_phase;
  logic       load_strobe;
  logic       rst_n_pix_req;
  logic       dvi_en;
  logic [1:0] state;
  logic       phase_err;

  smoldvi_bit_sequencer #(
    .DIV(DIV),
    .HIGH(HIGH),
    .SETTLE_CYCLES(SETTLE),
    .LOAD_PHASE(LDP)
  ) dut (
    .clk_bit(clk_bit),
    .rst_n_bit(rst_n_bit),
    .pll_lock(pll_lock),
    .en_req(en_req),
    .clr_err(clr_err),
    .clk_pix(clk_pix),
    .pix_phase(pix_phase),
    .load_strobe(load_strobe),
    .rst_n_pix_req(rst_n_pix_req),
    .dvi_en(dvi_en),
    .state(state),
    .phase_err(phase_err)
  );

  always #5 clk_bit = ~clk_bit;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int m_ph;
  int m_st;
  int m_age;
  bit m_rst;
  bit m_dvi;
  bit m_load;
  bit m_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({clk_pix, pix_phase, load_strobe,
                rst_n_pix_req, dvi_en, state, phase_err});
  endfunction

  function automatic logic [31:0] mdl_vec();
    logic ck;
    ck = (m_ph >= 1) && (m_ph <= HIGH);
    return 32'({ck, 4'(m_ph), m_load, m_rst,
                m_dvi, 2'(m_st), m_err});
  endfunction

  task automatic mdl_reset();
    m_ph = 0; m_st = 0; m_age = 0;
    m_rst = 0; m_dvi = 0; m_load = 0; m_err = 0;
  endtask

  task automatic mdl_step(input bit bad);
    int  nph;
    bit  nb;
    nph = bad ? 0 : (m_ph + 1) % DIV;
    nb  = (nph == BND);
    if (bad) m_err = 1;
    else if (clr_err) m_err = 0;
    if (!pll_lock) begin
      m_st = 0; m_rst = 0; m_dvi = 0; m_load = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_age = 0; m_rst = 0; m_dvi = 0; m_load = 0;
    end else if (bad) begin
      m_st = 1; m_age = 0; m_rst = 0; m_dvi = 0; m_load = 0;
    end else if (m_st == 1) begin
      m_load = 0;
      if (m_age >= SETTLE - 1 && nb) begin
        m_st = 2; m_rst = 1; m_dvi = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (nb) m_dvi = en_req;
      m_load = (nph == LDP) && m_dvi;
    end
    m_ph = nph;
  endtask

  // Called at a negedge with inputs already set.
  task automatic cyc();
    @(posedge clk_bit);
    mdl_step(1'b0);
    @(negedge clk_bit);
    check("cyc", dut_vec(), mdl_vec());
  endtask

  // Corrupt the ring for one edge, then hand it back.
  task automatic bad_cyc();
    force dut.r_ring = 5'b10100;
    @(posedge clk_bit);
    mdl_step(1'b1);
    #1;
    force dut.r_ring = 5'b11100;
    release dut.r_ring;
    @(negedge clk_bit);
    check("bad_cyc", dut_vec(), mdl_vec());
  endtask

  task automatic wait_run(input int lim);
    for (int i = 0; i < lim && state != 2'd2; i++) cyc();
    check("run_reached", 32'(state), 32'd2);
  endtask

  int n;

  initial begin
    mdl_reset();
    #1;
    check("rst_vals", dut_vec(), mdl_vec());
    @(negedge clk_bit);
    rst_n_bit = 1'b1;

    // divider free-runs in HOLD
    for (int i = 0; i < 50; i++) cyc();

    // lock and settle
    pll_lock = 1'b1;
    en_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && state != 2'd2; i++) begin
      cyc();
      if (state == 2'd1) n++;
    end
    check("settle_len", 32'(n >= 16 && n <= 20), 32'd1);
    check("run_phase", 32'(pix_phase), 32'd4);
    check("run_rstreq", 32'(rst_n_pix_req), 32'd1);
    for (int i = 0; i < 10 && !dvi_en; i++) cyc();
    check("dvi_phase", 32'(pix_phase), 32'd4);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (load_strobe) n++;
    end
    check("load_cnt", 32'(n), 32'd5);

    // drop enable at an odd phase
    cyc();
    cyc();
    en_req = 1'b0;
    for (int i = 0; i < 10 && dvi_en; i++) cyc();
    check("dvi_off_ph", 32'(pix_phase), 32'd4);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (load_strobe) n++;
    end
    check("load_off", 32'(n), 32'd0);
    en_req = 1'b1;

    // random enable and clear traffic in RUN
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) en_req = ~en_req;
      clr_err = ($urandom_range(0, 15) == 0);
      cyc();
    end
    clr_err = 1'b0;
    en_req = 1'b1;

    // ring corruption in RUN
    wait_run(60);
    cyc();
    bad_cyc();
    check("err_set", 32'(phase_err), 32'd1);
    check("err_phase", 32'(pix_phase), 32'd0);
    check("err_state", 32'(state), 32'd1);
    check("err_rstreq", 32'(rst_n_pix_req), 32'd0);
    check("err_dvi", 32'(dvi_en), 32'd0);
    check("ring_reload", 32'(dut.r_ring), 32'h1c);
    wait_run(60);
    check("err_sticky", 32'(phase_err), 32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("err_clr", 32'(phase_err), 32'd0);

    // one-cycle lock loss
    for (int i = 0; i < 7; i++) cyc();
    pll_lock = 1'b0;
    cyc();
    check("lock_hold", 32'(state), 32'd0);
    check("lock_dvi", 32'(dvi_en), 32'd0);
    pll_lock = 1'b1;
    wait_run(60);

    // mixed random run
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) en_req = ~en_req;
      clr_err = ($urandom_range(0, 15) == 0);
      pll_lock = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 149) == 0) bad_cyc();
      else cyc();
    end
    clr_err = 1'b0;
    pll_lock = 1'b1;
    en_req = 1'b1;

    // async reset mid-RUN at phase 2
    wait_run(60);
    for (int i = 0; i < 10 && m_ph != 2; i++) cyc();
    check("pre_rst_ph", 32'(pix_phase), 32'd2);
    #2;
    rst_n_bit = 1'b0;
    mdl_reset();
    #1;
    check("async_rst", dut_vec(), mdl_vec());
    @(negedge clk_bit);
    @(negedge clk_bit);
    check("in_rst", dut_vec(), mdl_vec());
    pll_lock = 1'b0;
    rst_n_bit = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
